alu_csr_datapath: RTL and testbench



---
 rtl/alu_csr_datapath.sv | 206 ++++++++++++++++++++
 tb/tb_alu_csr_datapath.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_csr_datapath.sv
// rtl/alu_csr_datapath.sv - RV32 EX-stage ALU and CSR read-modify-write datapath (optional multiply: ALU_MUL_EN)
module alu_csr_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  instr_id,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic [4:0]  rs1_addr,
  input  logic [31:0] csr_read_data,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        csr_write_enable,
  output logic [31:0] csr_write_data
);

  // Decoded instruction IDs
  localparam logic [5:0] ID_ADD    = 6'h01;
  localparam logic [5:0] ID_SUB    = 6'h02;
  localparam logic [5:0] ID_XOR    = 6'h03;
  localparam logic [5:0] ID_OR     = 6'h04;
  localparam logic [5:0] ID_AND    = 6'h05;
  localparam logic [5:0] ID_SLL    = 6'h06;
  localparam logic [5:0] ID_SRL    = 6'h07;
  localparam logic [5:0] ID_SRA    = 6'h08;
  localparam logic [5:0] ID_SLT    = 6'h09;
  localparam logic [5:0] ID_SLTU   = 6'h0A;
  localparam logic [5:0] ID_ADDI   = 6'h0B;
  localparam logic [5:0] ID_XORI   = 6'h0C;
  localparam logic [5:0] ID_ORI    = 6'h0D;
  localparam logic [5:0] ID_ANDI   = 6'h0E;
  localparam logic [5:0] ID_SLLI   = 6'h0F;
  localparam logic [5:0] ID_SRLI   = 6'h10;
  localparam logic [5:0] ID_SRAI   = 6'h11;
  localparam logic [5:0] ID_SLTI   = 6'h12;
  localparam logic [5:0] ID_SLTIU  = 6'h13;
  localparam logic [5:0] ID_LB     = 6'h14;
  localparam logic [5:0] ID_LH     = 6'h15;
  localparam logic [5:0] ID_LW     = 6'h16;
  localparam logic [5:0] ID_LBU    = 6'h17;
  localparam logic [5:0] ID_LHU    = 6'h18;
  localparam logic [5:0] ID_SB     = 6'h19;
  localparam logic [5:0] ID_SH     = 6'h1A;
  localparam logic [5:0] ID_SW     = 6'h1B;
  localparam logic [5:0] ID_BEQ    = 6'h1C;
  localparam logic [5:0] ID_BNE    = 6'h1D;
  localparam logic [5:0] ID_BLT    = 6'h1E;
  localparam logic [5:0] ID_BGE    = 6'h1F;
  localparam logic [5:0] ID_BLTU   = 6'h20;
  localparam logic [5:0] ID_BGEU   = 6'h21;
  localparam logic [5:0] ID_JAL    = 6'h22;
  localparam logic [5:0] ID_JALR   = 6'h23;
  localparam logic [5:0] ID_LUI    = 6'h24;
  localparam logic [5:0] ID_AUIPC  = 6'h25;
  localparam logic [5:0] ID_CSRRW  = 6'h26;
  localparam logic [5:0] ID_CSRRS  = 6'h27;
  localparam logic [5:0] ID_CSRRC  = 6'h28;
  localparam logic [5:0] ID_CSRRWI = 6'h29;
  localparam logic [5:0] ID_CSRRSI = 6'h2A;
  localparam logic [5:0] ID_CSRRCI = 6'h2B;
`ifdef ALU_MUL_EN
  localparam logic [5:0] ID_MUL    = 6'h2C;
  localparam logic [5:0] ID_MULH   = 6'h2D;
  localparam logic [5:0] ID_MULHSU = 6'h2E;
  localparam logic [5:0] ID_MULHU  = 6'h2F;
`endif

  logic [31:0] uimm;
  logic        csr_has_src;
  logic [31:0] calc_result;
  logic        calc_we;
  logic [31:0] calc_wdata;

  logic        out_valid_d, out_valid_q;
  logic [31:0] result_d, result_q;
  logic        csr_we_d, csr_we_q;
  logic [31:0] csr_wdata_d, csr_wdata_q;

  assign uimm        = {27'd0, rs1_addr};
  // Set/clear forms only write when the source register/uimm field is non-zero
  assign csr_has_src = (rs1_addr != 5'd0);

`ifdef ALU_MUL_EN
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [65:0] mul_p;
  logic [1:0]         unused_mul_top;

  // Extend operands to 33 bits so one signed multiplier covers all signedness mixes
  always_comb begin
    mul_a = {(instr_id != ID_MULHU) & rs1[31], rs1};
    mul_b = {((instr_id == ID_MUL) | (instr_id == ID_MULH)) & rs2[31], rs2};
  end

  assign mul_p          = mul_a * mul_b;
  assign unused_mul_top = mul_p[65:64];
`endif

  // Combinational ALU / CSR value generation for the instruction being sampled
  always_comb begin
    calc_result = 32'd0;
    calc_we     = 1'b0;
    calc_wdata  = 32'd0;
    case (instr_id)
      ID_ADD:   calc_result = rs1 + rs2;
      ID_SUB:   calc_result = rs1 - rs2;
      ID_XOR:   calc_result = rs1 ^ rs2;
      ID_OR:    calc_result = rs1 | rs2;
      ID_AND:   calc_result = rs1 & rs2;
      ID_SLL:   calc_result = rs1 << rs2[4:0];
      ID_SRL:   calc_result = rs1 >> rs2[4:0];
      ID_SRA:   calc_result = $unsigned($signed(rs1) >>> rs2[4:0]);
      ID_SLT:   calc_result = {31'd0, $signed(rs1) < $signed(rs2)};
      ID_SLTU:  calc_result = {31'd0, rs1 < rs2};
      ID_ADDI:  calc_result = rs1 + imm;
      ID_XORI:  calc_result = rs1 ^ imm;
      ID_ORI:   calc_result = rs1 | imm;
      ID_ANDI:  calc_result = rs1 & imm;
      ID_SLLI:  calc_result = rs1 << imm[4:0];
      ID_SRLI:  calc_result = rs1 >> imm[4:0];
      ID_SRAI:  calc_result = $unsigned($signed(rs1) >>> imm[4:0]);
      ID_SLTI:  calc_result = {31'd0, $signed(rs1) < $signed(imm)};
      ID_SLTIU: calc_result = {31'd0, rs1 < imm};
      ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
      ID_SB, ID_SH, ID_SW:
                calc_result = rs1 + imm;
      ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU:
                calc_result = 32'd0;
      ID_JAL, ID_JALR:
                calc_result = pc + 32'd4;
      ID_LUI:   calc_result = imm;
      ID_AUIPC: calc_result = pc + imm;
      ID_CSRRW: begin
        calc_result = csr_read_data;
        calc_wdata  = rs1;
        calc_we     = 1'b1;
      end
      ID_CSRRS: begin
        calc_result = csr_read_data;
        calc_wdata  = csr_read_data | rs1;
        calc_we     = csr_has_src;
      end
      ID_CSRRC: begin
        calc_result = csr_read_data;
        calc_wdata  = csr_read_data & ~rs1;
        calc_we     = csr_has_src;
      end
      ID_CSRRWI: begin
        calc_result = csr_read_data;
        calc_wdata  = uimm;
        calc_we     = 1'b1;
      end
      ID_CSRRSI: begin
        calc_result = csr_read_data;
        calc_wdata  = csr_read_data | uimm;
        calc_we     = csr_has_src;
      end
      ID_CSRRCI: begin
        calc_result = csr_read_data;
        calc_wdata  = csr_read_data & ~uimm;
        calc_we     = csr_has_src;
      end
`ifdef ALU_MUL_EN
      ID_MUL:   calc_result = mul_p[31:0];
      ID_MULH, ID_MULHSU, ID_MULHU:
                calc_result = mul_p[63:32];
`endif
      default:  calc_result = 32'd0;
    endcase
  end

  // Next-state: idle cycles drop the strobes but keep the last data values
  always_comb begin
    out_valid_d = in_valid;
    csr_we_d    = in_valid & calc_we;
    result_d    = result_q;
    csr_wdata_d = csr_wdata_q;
    if (in_valid) begin
      result_d    = calc_result;
      csr_wdata_d = calc_wdata;
    end
  end

  // Output registers with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      csr_we_q    <= 1'b0;
      csr_wdata_q <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      csr_we_q    <= csr_we_d;
      csr_wdata_q <= csr_wdata_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign result           = result_q;
  assign csr_write_enable = csr_we_q;
  assign csr_write_data   = csr_wdata_q;

endmodule

// File: tb/tb_alu_csr_datapath.sv
// tb/tb_alu_csr_datapath.sv - directed and randomized self-checking bench for alu_csr_datapath
module tb_alu_csr_datapath;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  instr_id;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [4:0]  rs1_addr;
  logic [31:0] csr_read_data;
  logic        out_valid;
  logic [31:0] result;
  logic        csr_write_enable;
  logic [31:0] csr_write_data;

  int n_cmp;
  int n_err;

  logic        exp_valid;
  logic [31:0] exp_result;
  logic        exp_we;
  logic [31:0] exp_wdata;

  alu_csr_datapath dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .instr_id         (instr_id),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .pc               (pc),
    .rs1_addr         (rs1_addr),
    .csr_read_data    (csr_read_data),
    .out_valid        (out_valid),
    .result           (result),
    .csr_write_enable (csr_write_enable),
    .csr_write_data   (csr_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: I-type ops fold onto their R-type counterpart with imm as operand 2
  function automatic void model(input logic [5:0] id, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] im, input logic [31:0] p, input logic [4:0] ad,
                                input logic [31:0] c, output logic [31:0] r, output logic we,
                                output logic [31:0] wd);
    logic [5:0]  op;
    logic [31:0] o2;
    logic [31:0] src;
    int          sh;
    longint      sprod;
    logic [63:0] uprod;
    r  = 0;
    we = 0;
    wd = 0;
    op = id;
    o2 = b;
    if (id >= 6'h0B && id <= 6'h13) begin
      o2 = im;
      op = (id == 6'h0B) ? 6'h01 : id - 6'd9;
    end
    sh = int'(o2 % 32);
    if (op >= 6'h01 && op <= 6'h0A) begin
      case (op)
        6'h01: r = a + o2;
        6'h02: r = a - o2;
        6'h03: r = a ^ o2;
        6'h04: r = a | o2;
        6'h05: r = a & o2;
        6'h06: r = a * (32'd1 << sh);
        6'h07: r = a / (33'd1 << sh);
        6'h08: begin
          sprod = longint'($signed(a));
          r = 32'(sprod >>> sh);
        end
        6'h09: r = (longint'($signed(a)) < longint'($signed(o2))) ? 1 : 0;
        default: r = ({32'd0, a} < {32'd0, o2}) ? 1 : 0;
      endcase
    end else if (id >= 6'h14 && id <= 6'h1B) r = a + im;
    else if (id >= 6'h1C && id <= 6'h21) r = 0;
    else if (id == 6'h22 || id == 6'h23) r = p + 4;
    else if (id == 6'h24) r = im;
    else if (id == 6'h25) r = p + im;
    else if (id >= 6'h26 && id <= 6'h2B) begin
      r   = c;
      src = (id >= 6'h29) ? {27'd0, ad} : a;
      case ((id - 6'h26) % 3)
        0: begin wd = src;      we = 1;        end
        1: begin wd = c | src;  we = (ad != 0); end
        default: begin wd = c & ~src; we = (ad != 0); end
      endcase
    end
`ifdef ALU_MUL_EN
    else if (id == 6'h2C) begin
      uprod = {32'd0, a} * {32'd0, b};
      r = uprod[31:0];
    end else if (id == 6'h2D) begin
      sprod = longint'($signed(a)) * longint'($signed(b));
      r = 32'(sprod >>> 32);
    end else if (id == 6'h2E) begin
      sprod = longint'($signed(a)) * longint'({32'd0, b});
      r = 32'(sprod >>> 32);
    end else if (id == 6'h2F) begin
      uprod = {32'd0, a} * {32'd0, b};
      r = uprod[63:32];
    end
`endif
  endfunction

  // Apply one instruction slot, clock it, and compare all outputs against the model
  task automatic step(input logic v, input logic [5:0] id, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] p, input logic [4:0] ad,
                      input logic [31:0] c);
    logic [31:0] r;
    logic        we;
    logic [31:0] wd;
    in_valid      = v;
    instr_id      = id;
    rs1           = a;
    rs2           = b;
    imm           = im;
    pc            = p;
    rs1_addr      = ad;
    csr_read_data = c;
    @(posedge clk);
    #1;
    model(id, a, b, im, p, ad, c, r, we, wd);
    if (!rst_n) begin
      exp_valid  = 0;
      exp_we     = 0;
      exp_result = 0;
      exp_wdata  = 0;
    end else begin
      exp_valid = v;
      exp_we    = v & we;
      if (v) begin
        exp_result = r;
        exp_wdata  = wd;
      end
    end
    chk($sformatf("valid id=%h", id), {31'd0, out_valid}, {31'd0, exp_valid});
    chk($sformatf("result id=%h", id), result, exp_result);
    chk($sformatf("we id=%h", id), {31'd0, csr_write_enable}, {31'd0, exp_we});
    chk($sformatf("wdata id=%h", id), csr_write_data, exp_wdata);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_valid = 0; exp_result = 0; exp_we = 0; exp_wdata = 0;
    rst_n = 0;
    in_valid = 0; instr_id = 0; rs1 = 0; rs2 = 0; imm = 0; pc = 0; rs1_addr = 0; csr_read_data = 0;
    @(negedge clk);

    // Reset wins over a valid ADD
    step(1, 6'h01, 32'd5, 32'd7, 0, 0, 0, 0);
    step(1, 6'h01, 32'd5, 32'd7, 0, 0, 0, 0);
    chk("reset valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset we", {31'd0, csr_write_enable}, 32'd0);
    chk("reset wdata", csr_write_data, 32'd0);
    rst_n = 1;

    step(1, 6'h01, 32'd5, 32'd7, 0, 0, 0, 0);
    chk("add 5+7", result, 32'd12);
    chk("add valid", {31'd0, out_valid}, 32'd1);

    step(0, 6'h02, 32'd99, 32'd98, 0, 0, 0, 0);
    chk("idle hold", result, 32'd12);
    chk("idle valid", {31'd0, out_valid}, 32'd0);
    chk("idle we", {31'd0, csr_write_enable}, 32'd0);

    step(1, 6'h02, 32'd0, 32'd1, 0, 0, 0, 0);
    chk("sub 0-1", result, 32'hFFFF_FFFF);
    step(1, 6'h08, 32'h8000_0000, 32'd4, 0, 0, 0, 0);
    chk("sra", result, 32'hF800_0000);
    step(1, 6'h07, 32'h8000_0000, 32'd4, 0, 0, 0, 0);
    chk("srl", result, 32'h0800_0000);
    step(1, 6'h09, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    chk("slt", result, 32'd1);
    step(1, 6'h0A, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    chk("sltu", result, 32'd0);
    step(1, 6'h13, 32'd5, 0, 32'hFFFF_FFFF, 0, 0, 0);
    chk("sltiu", result, 32'd1);
    step(1, 6'h22, 0, 0, 0, 32'h100, 0, 0);
    chk("jal", result, 32'h104);
    step(1, 6'h25, 0, 0, 32'h2000, 32'h1000, 0, 0);
    chk("auipc", result, 32'h3000);
    step(1, 6'h24, 0, 0, 32'hABCD_E000, 0, 0, 0);
    chk("lui", result, 32'hABCD_E000);

    step(1, 6'h27, 32'h0F, 0, 0, 0, 5'd3, 32'hF0);
    chk("csrrs result", result, 32'hF0);
    chk("csrrs we", {31'd0, csr_write_enable}, 32'd1);
    chk("csrrs wdata", csr_write_data, 32'hFF);
    step(1, 6'h27, 32'h0F, 0, 0, 0, 5'd0, 32'hF0);
    chk("csrrs x0 we", {31'd0, csr_write_enable}, 32'd0);
    chk("csrrs x0 wdata", csr_write_data, 32'hFF);
    step(1, 6'h2B, 32'hFFFF_FFFF, 0, 0, 0, 5'h10, 32'hF0);
    chk("csrrci wdata", csr_write_data, 32'hE0);
    step(1, 6'h29, 32'h1234, 0, 0, 0, 5'd0, 32'hF0);
    chk("csrrwi we", {31'd0, csr_write_enable}, 32'd1);
    chk("csrrwi wdata", csr_write_data, 32'd0);

    step(1, 6'h3F, 32'd3, 32'd4, 32'd5, 32'd6, 5'd7, 32'd8);
    chk("unknown result", result, 32'd0);
    chk("unknown we", {31'd0, csr_write_enable}, 32'd0);

`ifdef ALU_MUL_EN
    step(1, 6'h2D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("mulh", result, 32'd0);
    step(1, 6'h2F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("mulhu", result, 32'hFFFF_FFFE);
    step(1, 6'h2C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("mul", result, 32'd1);
`else
    step(1, 6'h2C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("mul disabled", result, 32'd0);
`endif

    // Randomized traffic, including idle slots, x0/uimm=0 CSR forms and a mid-run reset
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      v = ($urandom_range(0, 7) != 0);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
      rst_n = (i != 200);
      step(v, 6'($urandom_range(0, 63)), a, b, $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
      rst_n = 1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
